// File: rtl/uart_core_if.sv
// Host-side byte interface of uart_core: transmit request/status and receive result.
// master = host logic, slave = the UART.
interface uart_core_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_done, rx_data, rx_done, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_done, rx_data, rx_done, rx_frame_err
  );
endinterface

// File: rtl/uart_core.sv
// 8N1 UART: 16x oversample tick generator, transmitter and mid-bit sampling receiver.
// All outputs are registered; reset is synchronous, active-low.
module uart_core #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic        clk,
  input  logic        reset,
  uart_core_if.slave  host,
  output logic        tx,
  input  logic        rx,
  output logic        baud_tick
);

  localparam int OS_DIV = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(OS_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  logic [CW-1:0] div_q, div_d;
  logic          baud_tick_q;

  state_e        tx_state_q;
  logic          tx_q, tx_busy_q, tx_done_q;
  logic [3:0]    tx_os_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_shr_q;

  logic          rx_s1_q, rx_s2_q;
  state_e        rx_state_q;
  logic [3:0]    rx_os_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shr_q, rx_data_q;
  logic          rx_done_q, rx_err_q;

  always_comb begin
    div_d = div_q + CW'(1);
    if (div_q == DIV_LAST) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q       <= '0;
      baud_tick_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      baud_tick_q <= (div_q == DIV_LAST);
    end
  end

  // Bit timing restarts at acceptance, so the start bit absorbs the tick phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_os_q    <= 4'd0;
      tx_idx_q   <= 3'd0;
      tx_shr_q   <= 8'h00;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (host.tx_start) begin
            tx_shr_q   <= host.tx_data;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_os_q    <= 4'd0;
            tx_state_q <= ST_START;
          end
        end
        default: begin
          if (baud_tick_q) begin
            if (tx_os_q != 4'd15) begin
              tx_os_q <= tx_os_q + 4'd1;
            end else begin
              tx_os_q <= 4'd0;
              case (tx_state_q)
                ST_START: begin
                  tx_state_q <= ST_DATA;
                  tx_idx_q   <= 3'd0;
                  tx_q       <= tx_shr_q[0];
                end
                ST_DATA: begin
                  if (tx_idx_q == 3'd7) begin
                    tx_state_q <= ST_STOP;
                    tx_q       <= 1'b1;
                  end else begin
                    tx_idx_q <= tx_idx_q + 3'd1;
                    tx_q     <= tx_shr_q[tx_idx_q + 3'd1];
                  end
                end
                default: begin
                  tx_state_q <= ST_IDLE;
                  tx_busy_q  <= 1'b0;
                  tx_done_q  <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // Leaving STOP at mid-bit lets a back-to-back start edge be caught.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_os_q    <= 4'd0;
      rx_idx_q   <= 3'd0;
      rx_shr_q   <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      if (baud_tick_q) begin
        case (rx_state_q)
          ST_IDLE: begin
            if (!rx_s2_q) begin
              rx_state_q <= ST_START;
              rx_os_q    <= 4'd0;
            end
          end
          ST_START: begin
            if (rx_os_q == 4'd7) begin
              rx_os_q    <= 4'd0;
              rx_idx_q   <= 3'd0;
              rx_state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
            end else begin
              rx_os_q <= rx_os_q + 4'd1;
            end
          end
          ST_DATA: begin
            if (rx_os_q == 4'd15) begin
              rx_os_q  <= 4'd0;
              rx_shr_q <= {rx_s2_q, rx_shr_q[7:1]};
              if (rx_idx_q == 3'd7) rx_state_q <= ST_STOP;
              else                  rx_idx_q   <= rx_idx_q + 3'd1;
            end else begin
              rx_os_q <= rx_os_q + 4'd1;
            end
          end
          default: begin
            if (rx_os_q == 4'd15) begin
              rx_os_q    <= 4'd0;
              rx_state_q <= ST_IDLE;
              if (rx_s2_q) begin
                rx_data_q <= rx_shr_q;
                rx_done_q <= 1'b1;
              end else begin
                rx_err_q  <= 1'b1;
              end
            end else begin
              rx_os_q <= rx_os_q + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign tx                = tx_q;
  assign baud_tick         = baud_tick_q;
  assign host.tx_busy      = tx_busy_q;
  assign host.tx_done      = tx_done_q;
  assign host.rx_data      = rx_data_q;
  assign host.rx_done      = rx_done_q;
  assign host.rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at a reduced divider (OS_DIV=4, 64 clks per bit).
// Expected values are hand-derived from the frame format and bit timing.
module tb_uart_core;

  localparam int CLK_F  = 640000;
  localparam int BAUD   = 10000;
  localparam int OSD    = 4;
  localparam int BIT    = 64;

  logic clk = 1'b0;
  logic reset;
  logic tx, rx_line, baud_tick;
  logic loop_en, rx_drv;

  int n_checks = 0;
  int n_errors = 0;

  int n_txd = 0, n_rxd = 0, n_err = 0, n_viol = 0;
  logic p_txd = 1'b0, p_rxd = 1'b0, p_err = 1'b0;

  uart_core_if u_if ();

  uart_core #(.CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (u_if),
    .tx        (tx),
    .rx        (rx_line),
    .baud_tick (baud_tick)
  );

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.tx_done) n_txd++;
    if (u_if.rx_done) n_rxd++;
    if (u_if.rx_frame_err) n_err++;
    if (u_if.tx_done && p_txd) n_viol++;
    if (u_if.rx_done && p_rxd) n_viol++;
    if (u_if.rx_frame_err && p_err) n_viol++;
    if (u_if.rx_done && u_if.rx_frame_err) n_viol++;
    p_txd = u_if.tx_done;
    p_rxd = u_if.rx_done;
    p_err = u_if.rx_frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    u_if.tx_data  = d;
    u_if.tx_start = 1'b1;
    @(negedge clk);
    u_if.tx_start = 1'b0;
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (tx === v && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_tx_done(output int n);
    n = 0;
    while (u_if.tx_done !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rx_done(output int n);
    n = 0;
    while (u_if.rx_done !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = d[k];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    int n, b_txd, b_rxd, b_err;

    reset         = 1'b0;
    loop_en       = 1'b0;
    rx_drv        = 1'b1;
    u_if.tx_data  = 8'h00;
    u_if.tx_start = 1'b0;

    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", u_if.tx_busy, 0);
    check("rst_rx_data", u_if.rx_data, 8'h00);
    check("rst_pulses", {u_if.tx_done, u_if.rx_done, u_if.rx_frame_err, baud_tick}, 0);

    reset = 1'b1;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (baud_tick) begin
        n = i;
        break;
      end
    end
    check("first_tick", n, OSD);

    // Bit order with 8'h01: start low, bit0 high, bits1..7 low, stop high.
    @(negedge clk);
    send(8'h01);
    check("start_tx_low", tx, 0);
    check("start_busy", u_if.tx_busy, 1);
    run_len(1'b0, n);
    check("start_len_ok", (n >= 15*OSD+1) && (n <= 16*OSD), 1);
    run_len(1'b1, n);
    check("bit0_len", n, BIT);
    run_len(1'b0, n);
    check("bits1_7_len", n, 7*BIT);
    wait_tx_done(n);
    check("stop_len", n, BIT);
    check("done_busy_clr", u_if.tx_busy, 0);
    check("done_tx_idle", tx, 1);

    // Loopback of 8'hAA
    repeat (20) @(negedge clk);
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    b_txd = n_txd; b_rxd = n_rxd; b_err = n_err;
    send(8'hAA);
    wait_rx_done(n);
    check("aa_rx_timeout", n < 2000, 1);
    wait_tx_done(n);
    check("aa_tx_timeout", n < 2000, 1);
    repeat (200) @(negedge clk);
    check("aa_rx_data", u_if.rx_data, 8'hAA);
    check("aa_tx_done_cnt", n_txd - b_txd, 1);
    check("aa_rx_done_cnt", n_rxd - b_rxd, 1);
    check("aa_err_cnt", n_err - b_err, 0);

    // Busy rejection: second request with 8'hFF mid-frame must be dropped
    b_txd = n_txd; b_rxd = n_rxd;
    send(8'h55);
    repeat (200) @(negedge clk);
    send(8'hFF);
    check("busy_during", u_if.tx_busy, 1);
    wait_tx_done(n);
    check("busy_tx_timeout", n < 2000, 1);
    repeat (900) @(negedge clk);
    check("busy_rx_data", u_if.rx_data, 8'h55);
    check("busy_tx_done_cnt", n_txd - b_txd, 1);
    check("busy_rx_done_cnt", n_rxd - b_rxd, 1);
    check("busy_idle", {u_if.tx_busy, tx}, 2'b01);

    // RX driven directly
    loop_en = 1'b0;
    repeat (20) @(negedge clk);
    b_rxd = n_rxd; b_err = n_err;
    drive_frame(8'h81, 1'b1);
    repeat (100) @(negedge clk);
    check("rx81_data", u_if.rx_data, 8'h81);
    check("rx81_done_cnt", n_rxd - b_rxd, 1);

    b_rxd = n_rxd;
    rx_drv = 1'b0;
    repeat (3*OSD) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    check("false_start_done", n_rxd - b_rxd, 0);
    check("false_start_err", n_err - b_err, 0);

    drive_frame(8'h3C, 1'b0);
    repeat (400) @(negedge clk);
    check("ferr_cnt", n_err - b_err, 1);
    check("ferr_done_cnt", n_rxd - b_rxd, 0);
    check("ferr_rx_data", u_if.rx_data, 8'h81);

    // Reset in the middle of data bit 4
    b_txd = n_txd;
    send(8'h5A);
    repeat (5*BIT + 30) @(negedge clk);
    check("mid_busy", u_if.tx_busy, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", u_if.tx_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (800) @(negedge clk);
    check("mid_rst_no_done", n_txd - b_txd, 0);
    check("mid_rst_idle_tx", tx, 1);

    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    send(8'hC3);
    wait_rx_done(n);
    check("post_rst_rx_timeout", n < 2000, 1);
    @(negedge clk);
    check("post_rst_rx_data", u_if.rx_data, 8'hC3);
    wait_tx_done(n);
    check("post_rst_tx_timeout", n < 2000, 1);
    repeat (20) @(negedge clk);

    check("pulse_width_excl", n_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
